// File: rtl/register_file.sv
// register_file: 32 x 32-bit dual-read, single-write general register file with
// a per-register in-flight write scoreboard. R0 reads as zero and ignores
// writes and issues. Reads bypass the write-back value landing this cycle.
module register_file #(
   parameter int DEPTH_BITS = 2
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [4:0]  AA,
   input  logic [4:0]  BA,
   input  logic        USE_A,
   input  logic        USE_B,
   output logic [31:0] A_DATA,
   output logic [31:0] B_DATA,
   input  logic        ISSUE_RW,
   input  logic [4:0]  ISSUE_DA,
   input  logic        WB_RW,
   input  logic [4:0]  WB_DA,
   input  logic [31:0] BUS_D,
   output logic        STALL
);

   localparam logic [DEPTH_BITS-1:0] CNT_MAX = {DEPTH_BITS{1'b1}};
   localparam logic [DEPTH_BITS-1:0] CNT_ONE = DEPTH_BITS'(1);

   // Entry 0 is reset to zero and never written, so it stays zero; reads of
   // R0 are forced to zero explicitly anyway.
   logic [31:0]           regs [32];
   logic [DEPTH_BITS-1:0] cnt  [32];

   logic issue_req;
   logic full_issue;
   logic retire;
   logic eff_issue;

   // Write-first read: the write landing on this edge is returned immediately.
   function automatic logic [31:0] read_port(input logic [4:0] addr);
      if (addr == 5'd0)
         return '0;
      else if (WB_RW && (WB_DA == addr))
         return BUS_D;
      else
         return regs[addr];
   endfunction

   // A register retires one outstanding write when write-back targets it and
   // it actually has writes in flight; a stray write-back never underflows.
   function automatic logic retiring(input logic [4:0] r);
      return WB_RW && (WB_DA == r) && (r != 5'd0) && (cnt[r] != '0);
   endfunction

   // Busy ignores the write retiring this cycle, since the bypass forwards it.
   function automatic logic busy(input logic [4:0] r);
      if (r == 5'd0)
         return 1'b0;
      else if (retiring(r))
         return (cnt[r] - CNT_ONE) != '0;
      else
         return cnt[r] != '0;
   endfunction

   // Operand reads, hazard detection and the resulting issue/retire strobes.
   always_comb begin
      A_DATA     = read_port(AA);
      B_DATA     = read_port(BA);
      issue_req  = ISSUE_RW && (ISSUE_DA != 5'd0);
      full_issue = (cnt[ISSUE_DA] == CNT_MAX) && !retiring(ISSUE_DA);
      STALL      = (USE_A && busy(AA)) || (USE_B && busy(BA)) ||
                   (issue_req && full_issue);
      eff_issue  = issue_req && !STALL;
      retire     = retiring(WB_DA);
   end

   // Scoreboard counters: issue increments, retire decrements, both cancel.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int r = 0; r < 32; r++)
            cnt[r] <= '0;
      end else begin
         if (eff_issue && !(retire && (WB_DA == ISSUE_DA)))
            cnt[ISSUE_DA] <= cnt[ISSUE_DA] + CNT_ONE;
         if (retire && !(eff_issue && (WB_DA == ISSUE_DA)))
            cnt[WB_DA] <= cnt[WB_DA] - CNT_ONE;
      end
   end

   // Register storage: cleared on reset, otherwise written by write-back.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int r = 0; r < 32; r++)
            regs[r] <= '0;
      end else if (WB_RW && (WB_DA != 5'd0)) begin
         regs[WB_DA] <= BUS_D;
      end
   end

endmodule
